// File: rtl/traffic_light_fsm_if.sv
// Signal bundle between the synchronizer-side controller logic and the light sequencer.
// The master drives the synchronized requests and tick; the slave drives the lamps.
interface traffic_light_fsm_if;
    logic       Tick;
    logic       Sensor_Sync;
    logic       WR_Sync;
    logic       Prog_Sync;
    logic [1:0] Time_Param_Selector;
    logic [3:0] Time_Value;
    logic [2:0] Main_LEDs;
    logic [2:0] Side_LEDs;
    logic       Walk_Lamp;
    logic [2:0] State_Out;

    modport master (
        output Tick, Sensor_Sync, WR_Sync, Prog_Sync, Time_Param_Selector, Time_Value,
        input  Main_LEDs, Side_LEDs, Walk_Lamp, State_Out
    );

    modport slave (
        input  Tick, Sensor_Sync, WR_Sync, Prog_Sync, Time_Param_Selector, Time_Value,
        output Main_LEDs, Side_LEDs, Walk_Lamp, State_Out
    );
endinterface

// File: rtl/traffic_light_fsm.sv
// Intersection light sequencer: state machine, interval down-counter, walk latch
// and three programmable interval registers. Lamps are registered from the next state.
//
// state | meaning
// MG1   | main green, first interval
// MG2   | main green, extension (t_ext if side car waiting)
// MY    | main yellow
// WALK  | all red, pedestrian walk lamp on
// SG    | side green (t_base, plus t_ext if side car waiting)
// SY    | side yellow
module traffic_light_fsm #(
    parameter logic [3:0] T_BASE_DEF = 4'd6,
    parameter logic [3:0] T_EXT_DEF  = 4'd3,
    parameter logic [3:0] T_YEL_DEF  = 4'd2
) (
    input logic                 clk,
    input logic                 Reset_n,
    traffic_light_fsm_if.slave  bus
);

    localparam logic [2:0] MG1  = 3'd0;
    localparam logic [2:0] MG2  = 3'd1;
    localparam logic [2:0] MY   = 3'd2;
    localparam logic [2:0] WALK = 3'd3;
    localparam logic [2:0] SG   = 3'd4;
    localparam logic [2:0] SY   = 3'd5;

    logic [2:0] state, state_nxt;
    logic [4:0] count, count_nxt;
    logic       walk_pending, walk_nxt;
    logic [3:0] t_base, t_ext, t_yel;
    logic [4:0] sg_load;
    logic [2:0] main_nxt, side_nxt;
    logic       walk_lamp_nxt;

    // A programmed zero would stall the counter, so it is promoted to one everywhere.
    function automatic logic [4:0] eff(input logic [3:0] v);
        return (v == 4'd0) ? 5'd1 : {1'b0, v};
    endfunction

    assign sg_load = eff(t_base) + (bus.Sensor_Sync ? eff(t_ext) : 5'd0);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        walk_nxt  = walk_pending;
        if (bus.Prog_Sync) begin
            state_nxt = MG1;
            walk_nxt  = 1'b0;
            count_nxt = (bus.Time_Param_Selector == 2'b00) ? eff(bus.Time_Value) : eff(t_base);
        end else begin
            if (bus.WR_Sync && state != WALK)
                walk_nxt = 1'b1;
            if (bus.Tick) begin
                if (count > 5'd1) begin
                    count_nxt = count - 5'd1;
                end else begin
                    case (state)
                        MG1: begin
                            state_nxt = MG2;
                            count_nxt = bus.Sensor_Sync ? eff(t_ext) : eff(t_base);
                        end
                        MG2: begin
                            state_nxt = MY;
                            count_nxt = eff(t_yel);
                        end
                        MY: begin
                            if (walk_pending) begin
                                state_nxt = WALK;
                                count_nxt = eff(t_ext);
                                walk_nxt  = 1'b0;
                            end else begin
                                state_nxt = SG;
                                count_nxt = sg_load;
                            end
                        end
                        WALK: begin
                            state_nxt = SG;
                            count_nxt = sg_load;
                        end
                        SG: begin
                            state_nxt = SY;
                            count_nxt = eff(t_yel);
                        end
                        default: begin
                            state_nxt = MG1;
                            count_nxt = eff(t_base);
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        main_nxt      = 3'b100;
        side_nxt      = 3'b100;
        walk_lamp_nxt = 1'b0;
        case (state_nxt)
            MG1, MG2: main_nxt = 3'b001;
            MY:       main_nxt = 3'b010;
            WALK:     walk_lamp_nxt = 1'b1;
            SG:       side_nxt = 3'b001;
            SY:       side_nxt = 3'b010;
            default:  main_nxt = 3'b100;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state         <= MG1;
            count         <= eff(T_BASE_DEF);
            walk_pending  <= 1'b0;
            t_base        <= T_BASE_DEF;
            t_ext         <= T_EXT_DEF;
            t_yel         <= T_YEL_DEF;
            bus.Main_LEDs <= 3'b001;
            bus.Side_LEDs <= 3'b100;
            bus.Walk_Lamp <= 1'b0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            walk_pending  <= walk_nxt;
            bus.Main_LEDs <= main_nxt;
            bus.Side_LEDs <= side_nxt;
            bus.Walk_Lamp <= walk_lamp_nxt;
            if (bus.Prog_Sync) begin
                case (bus.Time_Param_Selector)
                    2'b00:   t_base <= bus.Time_Value;
                    2'b01:   t_ext  <= bus.Time_Value;
                    2'b10:   t_yel  <= bus.Time_Value;
                    default: ;
                endcase
            end
        end
    end

    assign bus.State_Out = state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm: directed timing scenarios plus random
// traffic, compared every cycle against a ticks-remaining reference model.
module tb_traffic_light_fsm;

    logic clk = 1'b0;
    logic Reset_n;
    traffic_light_fsm_if bus ();

    traffic_light_fsm #(.T_BASE_DEF(4'd6), .T_EXT_DEF(4'd3), .T_YEL_DEF(4'd2)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // stimulus levels applied on the next step
    bit       rst_v, tick_v, sensor_v, wr_v, prog_v;
    bit [1:0] sel_v;
    bit [3:0] val_v;
    int       tick_div = 0;
    int       tick_cnt = 0;

    // reference model: phase index, ticks left before leaving it, latch, parameters
    int m_phase, m_left, m_base, m_ext, m_yel;
    bit m_walk;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic logic [2:0] main_of(input int p);
        case (p)
            0, 1:    return 3'b001;
            2:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] side_of(input int p);
        case (p)
            4:       return 3'b001;
            5:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic model_update(input bit rst, input bit tk);
        int  old_phase;
        bit  entered_walk;
        old_phase    = m_phase;
        entered_walk = 1'b0;
        if (!rst) begin
            m_phase = 0; m_left = 6; m_base = 6; m_ext = 3; m_yel = 2; m_walk = 1'b0;
        end else if (prog_v) begin
            if (sel_v == 2'd0) m_base = val_v;
            if (sel_v == 2'd1) m_ext  = val_v;
            if (sel_v == 2'd2) m_yel  = val_v;
            m_phase = 0;
            m_left  = eff(m_base);
            m_walk  = 1'b0;
        end else begin
            if (tk) begin
                m_left--;
                if (m_left == 0) begin
                    case (old_phase)
                        0: begin m_phase = 1; m_left = sensor_v ? eff(m_ext) : eff(m_base); end
                        1: begin m_phase = 2; m_left = eff(m_yel); end
                        2: if (m_walk) begin
                               m_phase = 3; m_left = eff(m_ext); entered_walk = 1'b1;
                           end else begin
                               m_phase = 4; m_left = eff(m_base) + (sensor_v ? eff(m_ext) : 0);
                           end
                        3: begin m_phase = 4; m_left = eff(m_base) + (sensor_v ? eff(m_ext) : 0); end
                        4: begin m_phase = 5; m_left = eff(m_yel); end
                        default: begin m_phase = 0; m_left = eff(m_base); end
                    endcase
                end
            end
            if (entered_walk) m_walk = 1'b0;
            else if (wr_v && old_phase != 3) m_walk = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        bit tk;
        if (tick_div == 0) begin
            tk = tick_v;
        end else begin
            tk = (tick_cnt == tick_div - 1);
            tick_cnt = (tick_cnt + 1) % tick_div;
        end
        Reset_n                 = rst_v;
        bus.Tick                = tk;
        bus.Sensor_Sync         = sensor_v;
        bus.WR_Sync             = wr_v;
        bus.Prog_Sync           = prog_v;
        bus.Time_Param_Selector = sel_v;
        bus.Time_Value          = val_v;
        @(posedge clk);
        model_update(rst_v, tk);
        #1;
        check("state",  {5'd0, bus.State_Out}, 8'(m_phase));
        check("main",   {5'd0, bus.Main_LEDs}, {5'd0, main_of(m_phase)});
        check("side",   {5'd0, bus.Side_LEDs}, {5'd0, side_of(m_phase)});
        check("walk",   {7'd0, bus.Walk_Lamp}, {7'd0, (m_phase == 3)});
        check("conflict", {7'd0, (bus.Main_LEDs != 3'b100 && bus.Side_LEDs != 3'b100)}, 8'd0);
    endtask

    task automatic do_reset();
        rst_v = 1'b0;
        step();
        rst_v = 1'b1;
    endtask

    // expects the given state for exactly len sample points, then leaves the next state visible
    task automatic seg(input int s, input int len);
        for (int i = 0; i < len; i++) begin
            check("seg_state", {5'd0, bus.State_Out}, 8'(s));
            step();
        end
    endtask

    initial begin
        rst_v = 1'b1; tick_v = 1'b1; sensor_v = 1'b0; wr_v = 1'b0; prog_v = 1'b0;
        sel_v = 2'd0; val_v = 4'd0;
        m_phase = 0; m_left = 6; m_base = 6; m_ext = 3; m_yel = 2; m_walk = 1'b0;

        // default loop: 6/6/2/6/2
        do_reset();
        check("reset_main", {5'd0, bus.Main_LEDs}, 8'h01);
        check("reset_side", {5'd0, bus.Side_LEDs}, 8'h04);
        seg(0, 6); seg(1, 6); seg(2, 2); seg(4, 6); seg(5, 2); seg(0, 6);

        // side car held: MG2 = 3, SG = 9
        sensor_v = 1'b1;
        do_reset();
        seg(0, 6); seg(1, 3); seg(2, 2); seg(4, 9); seg(5, 2); seg(0, 6);
        sensor_v = 1'b0;

        // walk request in MG1, one walk only
        do_reset();
        wr_v = 1'b1; seg(0, 1); wr_v = 1'b0;
        seg(0, 5); seg(1, 6); seg(2, 2); seg(3, 3); seg(4, 6); seg(5, 2);
        seg(0, 6); seg(1, 6); seg(2, 2); seg(4, 6); seg(5, 2);

        // request during WALK is ignored
        do_reset();
        wr_v = 1'b1; seg(0, 1); wr_v = 1'b0;
        seg(0, 5); seg(1, 6); seg(2, 2);
        wr_v = 1'b1; seg(3, 1); wr_v = 1'b0;
        seg(3, 2); seg(4, 6); seg(5, 2); seg(0, 6); seg(1, 6); seg(2, 2); seg(4, 6);

        // reprogram base to 4 during SG
        do_reset();
        seg(0, 6); seg(1, 6); seg(2, 2); seg(4, 2);
        prog_v = 1'b1; sel_v = 2'd0; val_v = 4'd4; step(); prog_v = 1'b0;
        seg(0, 4); seg(1, 4); seg(2, 2); seg(4, 4); seg(5, 2); seg(0, 4);

        // selector 11 writes nothing
        do_reset();
        prog_v = 1'b1; sel_v = 2'd3; val_v = 4'd9; step(); prog_v = 1'b0;
        seg(0, 6); seg(1, 6); seg(2, 2); seg(4, 6); seg(5, 2);

        // yellow programmed to 0 acts as 1
        do_reset();
        prog_v = 1'b1; sel_v = 2'd2; val_v = 4'd0; step(); prog_v = 1'b0;
        seg(0, 6); seg(1, 6); seg(2, 1); seg(4, 6); seg(5, 1); seg(0, 6);

        // tick every 5th cycle: MG1 spans 30 cycles
        do_reset();
        tick_div = 5; tick_cnt = 0;
        seg(0, 30); seg(1, 5);
        tick_div = 0;

        // reset mid-SG aborts immediately
        do_reset();
        seg(0, 6); seg(1, 6); seg(2, 2); seg(4, 3);
        do_reset();
        check("midsg_reset_state", {5'd0, bus.State_Out}, 8'd0);
        check("midsg_reset_main",  {5'd0, bus.Main_LEDs}, 8'h01);
        seg(0, 6);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst_v    = ($urandom_range(0, 299) != 0);
            prog_v   = ($urandom_range(0, 119) == 0);
            sel_v    = 2'($urandom_range(0, 3));
            val_v    = 4'($urandom_range(0, 15));
            tick_v   = ($urandom_range(0, 2) != 0);
            sensor_v = ($urandom_range(0, 1) == 1);
            wr_v     = ($urandom_range(0, 24) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
